// File: rtl/divider_32bit.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock,
// results registered on completion and announced by a one-cycle done pulse.
module divider_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    // Handshake: start is a request honoured only in IDLE (ignored, never
    // queued, while busy); done is a one-cycle completion strobe and the
    // result outputs are valid from done until the next completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [32:0] r;
    logic [31:0] q;
    logic [31:0] d;
    logic [4:0]  cnt;

    logic [32:0] t;
    logic [32:0] diff;
    logic        ge;
    logic [32:0] r_next;
    logic [31:0] q_next;
    logic        last_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t         = {r[31:0], q[31]};
        diff      = t - {1'b0, d};
        ge        = (t >= {1'b0, d});
        r_next    = ge ? diff : t;
        q_next    = {q[30:0], ge};
        last_step = (cnt == 5'd31);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r           <= 33'd0;
            q           <= 32'd0;
            d           <= 32'd0;
            cnt         <= 5'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 32'd0) begin
                            r   <= 33'd0;
                            q   <= dividend;
                            d   <= divisor;
                            cnt <= 5'd0;
                        end else begin
                            // Divide-by-zero completes immediately with all-ones quotient.
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                    if (last_step) begin
                        quotient    <= q_next;
                        remainder   <= r_next[31:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_done_implies_busy : assert property (@(posedge clk) disable iff (reset) done |-> busy);
    a_done_one_cycle    : assert property (@(posedge clk) disable iff (reset) done |=> !done);

endmodule

// File: tb/tb_divider_32bit.sv
// Directed scoreboard bench for divider_32bit: driver pushes expected
// {quotient, remainder, div_by_zero}; a monitor pops on every done pulse.
module tb_divider_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [64:0] exp_q[$];
    logic [63:0] op_q[$];

    divider_32bit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                logic [64:0] e;
                logic [63:0] op;
                e  = exp_q.pop_front();
                op = op_q.pop_front();
                check("quotient", {32'd0, quotient}, {32'd0, e[64:33]});
                check("remainder", {32'd0, remainder}, {32'd0, e[32:1]});
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[0]});
                if (op[31:0] != 32'd0) begin
                    check("invariant_qdr", {32'd0, quotient} * {32'd0, op[31:0]} + {32'd0, remainder},
                          {32'd0, op[63:32]});
                    check("invariant_r_lt_d", {63'd0, (remainder < op[31:0])}, 64'd1);
                end
            end
        end
    end

    // Driver: called just after a falling edge with the DUT idle; returns
    // just after the falling edge that follows the return to IDLE.
    task automatic run_op(input logic [31:0] n, input logic [31:0] dv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input bit poke);
        int lat;
        bit busy_ok;
        dividend = n;
        divisor  = dv;
        start    = 1'b1;
        exp_q.push_back({eq, er, edz});
        op_q.push_back({n, dv});
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && lat == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy_during_op", {63'd0, busy_ok}, 64'd1);
        check("done_latency", lat, (dv == 32'd0) ? 64'd1 : 64'd33);
        if (poke) begin
            start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] n;
        logic [31:0] dv;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", {quotient, remainder}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        run_op(32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 1'b0);
        // Overlapping starts are ignored; next op issues right after DONE.
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        run_op(32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0, 1'b0);

        // Reset mid-operation aborts without a done pulse.
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", {quotient, remainder}, 64'd0);
        check("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        repeat (40) @(negedge clk);
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            n  = $urandom;
            dv = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 17 == 0) dv = 32'd0;
            if (dv == 32'd0)
                run_op(n, dv, 32'hFFFF_FFFF, n, 1'b1, 1'b0);
            else
                run_op(n, dv, n / dv, n % dv, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
